// File: rtl/account_bank.sv
// account_bank: per-user rating store with play counters and a multi-cycle clear-all sweep.
// Define ACCOUNT_BEST_EN to keep a per-user best slot-0 rating; otherwise best_rating is 0.
module account_bank #(
    parameter int NUM_USERS = 4,
    parameter int NUM_RATINGS = 2,
    parameter int RATING_W = 4,
    parameter int CNT_W = 4,
    parameter logic [1:0] EVAL_STATE = 2'd2,
    localparam int USER_W = $clog2(NUM_USERS),
    localparam int SLOT_W = NUM_RATINGS * RATING_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    state,
    input  logic [SLOT_W-1:0]             rating_in,
    input  logic                          userbtn,
    input  logic                          updatebtn,
    input  logic                          clearbtn,
    input  logic                          clearall,
    output logic [USER_W-1:0]             user,
    output logic                          busy,
    output logic [SLOT_W-1:0]             cur_ratings,
    output logic [CNT_W-1:0]              cur_count,
    output logic [NUM_USERS*SLOT_W-1:0]   all_ratings,
    output logic [RATING_W-1:0]           best_rating
);
    localparam logic IDLE = 1'b0;
    localparam logic SWEEP = 1'b1;
    localparam logic [USER_W-1:0] LAST = USER_W'(NUM_USERS - 1);

    logic [SLOT_W-1:0] ratings [NUM_USERS];
    logic [CNT_W-1:0]  counts  [NUM_USERS];
    logic              fsm;
    logic [USER_W-1:0] idx;
    logic              user_h, upd_h, clr_h, all_h;
    logic              accept, user_p, upd_p, clr_p, all_p;

    assign accept = (state == EVAL_STATE) && (fsm == IDLE);
    assign user_p = accept && userbtn && !user_h;
    assign upd_p  = accept && updatebtn && !upd_h;
    assign clr_p  = accept && clearbtn && !clr_h;
    assign all_p  = accept && clearall && !all_h;
    assign busy   = (fsm == SWEEP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {user_h, upd_h, clr_h, all_h} <= '0;
            user <= '0;
            fsm  <= IDLE;
            idx  <= '0;
        end else begin
            {user_h, upd_h, clr_h, all_h} <= {userbtn, updatebtn, clearbtn, clearall};
            if (user_p)
                user <= (user == LAST) ? '0 : user + 1'b1;
            if (fsm == SWEEP) begin
                idx <= idx + 1'b1;
                if (idx == LAST)
                    fsm <= IDLE;
            end else if (all_p) begin
                fsm <= SWEEP;
                idx <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int u = 0; u < NUM_USERS; u++) begin
                ratings[u] <= '0;
                counts[u]  <= '0;
            end
        end else begin
            for (int u = 0; u < NUM_USERS; u++) begin
                if ((fsm == SWEEP && idx == USER_W'(u)) || (clr_p && user == USER_W'(u))) begin
                    ratings[u] <= '0;
                    counts[u]  <= '0;
                end else if (upd_p && user == USER_W'(u)) begin
                    ratings[u] <= rating_in;
                    counts[u]  <= (counts[u] == '1) ? counts[u] : counts[u] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_USERS; g++) begin : g_all
        assign all_ratings[g*SLOT_W +: SLOT_W] = ratings[g];
    end

    assign cur_ratings = ratings[user];
    assign cur_count   = counts[user];

`ifdef ACCOUNT_BEST_EN
    logic [RATING_W-1:0] best [NUM_USERS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int u = 0; u < NUM_USERS; u++)
                best[u] <= '0;
        end else begin
            for (int u = 0; u < NUM_USERS; u++) begin
                if ((fsm == SWEEP && idx == USER_W'(u)) || (clr_p && user == USER_W'(u)))
                    best[u] <= '0;
                else if (upd_p && user == USER_W'(u) && rating_in[RATING_W-1:0] > best[u])
                    best[u] <= rating_in[RATING_W-1:0];
            end
        end
    end

    assign best_rating = best[user];
`else
    assign best_rating = '0;
`endif
endmodule

// File: tb/tb_account_bank.sv
// tb_account_bank: directed self-checking bench for account_bank with default parameters.
module tb_account_bank;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  state;
    logic [7:0]  rating_in;
    logic        userbtn, updatebtn, clearbtn, clearall;
    logic [1:0]  user;
    logic        busy;
    logic [7:0]  cur_ratings;
    logic [3:0]  cur_count;
    logic [31:0] all_ratings;
    logic [3:0]  best_rating;
    int          checks = 0;
    int          errors = 0;
    int          n;

    account_bank dut (
        .clk(clk), .reset(reset), .state(state), .rating_in(rating_in),
        .userbtn(userbtn), .updatebtn(updatebtn), .clearbtn(clearbtn), .clearall(clearall),
        .user(user), .busy(busy), .cur_ratings(cur_ratings), .cur_count(cur_count),
        .all_ratings(all_ratings), .best_rating(best_rating)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic upd(input logic [7:0] r);
        rating_in = r;
        updatebtn = 1'b1;
        tick();
        updatebtn = 1'b0;
        tick();
    endtask

    task automatic next_user();
        userbtn = 1'b1;
        tick();
        userbtn = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        state = 2'd2;
        rating_in = '0;
        {userbtn, updatebtn, clearbtn, clearall} = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rst_user", 32'(user), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_all", all_ratings, 0);
        chk("rst_count", 32'(cur_count), 0);
        chk("rst_best", 32'(best_rating), 0);

        rating_in = 8'h37;
        updatebtn = 1'b1;
        tick();
        updatebtn = 1'b0;
        chk("upd_ratings", 32'(cur_ratings), 32'h37);
        chk("upd_count", 32'(cur_count), 1);
        chk("upd_user", 32'(user), 0);
        tick();

        for (int i = 1; i <= 4; i++) begin
            next_user();
            chk("user_step", 32'(user), 32'(i % 4));
        end
        userbtn = 1'b1;
        repeat (10) tick();
        userbtn = 1'b0;
        tick();
        chk("user_hold", 32'(user), 1);

        rating_in = 8'hAB;
        updatebtn = 1'b1;
        clearbtn = 1'b1;
        tick();
        {updatebtn, clearbtn} = '0;
        tick();
        chk("clr_wins_ratings", 32'(cur_ratings), 0);
        chk("clr_wins_count", 32'(cur_count), 0);
        chk("clr_wins_user0", all_ratings, 32'h0000_0037);

        for (int i = 0; i < 17; i++) upd(8'h5A);
        chk("sat_count", 32'(cur_count), 15);
        chk("sat_ratings", 32'(cur_ratings), 32'h5A);

        rating_in = 8'hC4;
        userbtn = 1'b1;
        updatebtn = 1'b1;
        tick();
        {userbtn, updatebtn} = '0;
        tick();
        chk("combo_user", 32'(user), 2);
        chk("combo_all", all_ratings, 32'h0000_C437);
        chk("combo_count_new", 32'(cur_count), 0);

        upd(8'h12);
        next_user();
        upd(8'hEF);
        chk("load_all", all_ratings, 32'hEF12_C437);
        chk("load_user", 32'(user), 3);

        clearall = 1'b1;
        tick();
        clearall = 1'b0;
        userbtn = 1'b1;
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick();
        end
        userbtn = 1'b0;
        tick();
        chk("sweep_busy_cycles", 32'(n), 4);
        chk("sweep_user", 32'(user), 3);
        chk("sweep_all", all_ratings, 0);
        chk("sweep_count", 32'(cur_count), 0);

        upd(8'h99);
        chk("reload", all_ratings, 32'h9900_0000);
        clearall = 1'b1;
        tick();
        clearall = 1'b0;
        chk("sweep2_busy", 32'(busy), 1);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("midreset_busy", 32'(busy), 0);
        chk("midreset_all", all_ratings, 0);
        chk("midreset_user", 32'(user), 0);
        reset = 1'b1;
        tick();

        state = 2'd0;
        rating_in = 8'h44;
        updatebtn = 1'b1;
        userbtn = 1'b1;
        tick();
        {updatebtn, userbtn} = '0;
        tick();
        chk("idle_state_user", 32'(user), 0);
        chk("idle_state_ratings", 32'(cur_ratings), 0);
        chk("idle_state_count", 32'(cur_count), 0);
        state = 2'd2;
        tick();

        upd(8'h09);
        upd(8'h05);
        chk("best_ratings", 32'(cur_ratings), 32'h05);
`ifdef ACCOUNT_BEST_EN
        chk("best_max", 32'(best_rating), 9);
`else
        chk("best_tied", 32'(best_rating), 0);
`endif
        clearbtn = 1'b1;
        tick();
        clearbtn = 1'b0;
        tick();
        chk("best_clear", 32'(best_rating), 0);
        chk("best_clear_count", 32'(cur_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/account_bank.md
Name: account_bank

Overview:
- Parametrised per-user rating store for the piano evaluation flow.
- Holds NUM_USERS users, each with NUM_RATINGS ratings of RATING_W bits.
- Selects the active user, stores or clears the active user's ratings, and counts plays per user.
- Adds a multi-cycle clear-all sweep with a busy flag.
- Sits between the rating/scoring logic and the display/LED layer; it only acts while the top-level mode equals EVAL_STATE.

Parameters:
- NUM_USERS, 4, number of user slots (2..16, any value, need not be a power of two)
- NUM_RATINGS, 2, ratings stored per user (1..4)
- RATING_W, 4, bits per rating
- CNT_W, 4, bits of the per-user play counter
- EVAL_STATE, 2'd2, value of state in which the block accepts commands
- USER_W (localparam), $clog2(NUM_USERS), user index width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- state  in  2  top-level mode
- rating_in  in  NUM_RATINGS*RATING_W  ratings to store; slot k is bits [k*RATING_W +: RATING_W]
- userbtn  in  1  level, advance active user
- updatebtn  in  1  level, store rating_in to active user
- clearbtn  in  1  level, zero active user
- clearall  in  1  level, start sweep that zeroes all users
- user  out  USER_W  active user index
- busy  out  1  high while a sweep runs
- cur_ratings  out  NUM_RATINGS*RATING_W  stored ratings of the active user
- cur_count  out  CNT_W  play count of the active user
- all_ratings  out  NUM_USERS*NUM_RATINGS*RATING_W  every user's ratings; user u occupies bits [u*NUM_RATINGS*RATING_W +: NUM_RATINGS*RATING_W]
- best_rating  out  RATING_W  best slot-0 rating of the active user (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous):
  - user=0, busy=0, FSM=IDLE.
  - All stored ratings, counters and best registers are 0.
  - Button history registers are 0.
- Edge detect:
  - Each button has a history flop that is updated every cycle regardless of state.
  - A press is btn=1 while hist=0; it acts on that same clock edge.
  - Holding a button produces exactly one action.
- Commands are accepted only when state==EVAL_STATE and FSM==IDLE. Presses in any other case are discarded; they are not queued.
- userbtn press: user <= user+1. The value wraps from NUM_USERS-1 to 0, including non-power-of-two NUM_USERS.
- updatebtn press:
  - Active user's ratings <= rating_in.
  - Active user's count <= count+1, saturating at 2^CNT_W-1.
- clearbtn press: active user's ratings and count <= 0.
- Same-edge combinations:
  - clearbtn and updatebtn together: clear wins, count goes to 0.
  - userbtn together with update or clear: the update/clear targets the pre-increment user, and user advances on the same edge.
- clearall press moves the FSM from IDLE to SWEEP with an internal index idx=0 and busy=1.
- SWEEP:
  - Each cycle zeroes user idx's ratings, count and best, then idx++.
  - After clearing idx=NUM_USERS-1, the FSM returns to IDLE and busy=0.
  - busy is high for exactly NUM_USERS cycles.
  - user is unchanged by the sweep.
  - Button presses during SWEEP, and a clearall re-press, are ignored.
  - Leaving EVAL_STATE mid-sweep does not abort it.
- Reset asserted mid-sweep returns everything to the reset values immediately.
- Output timing:
  - cur_ratings, cur_count and best_rating are combinational muxes of registered storage indexed by user.
  - They show new data on the cycle after the acting edge.
  - all_ratings is a direct concatenation of storage.
- Values of rating_in are stored unmodified; no range checking.

Optional Feature:
- Macro ACCOUNT_BEST_EN.
- When defined, each user has a RATING_W best register.
  - On update: best <= max(best, rating_in slot 0), unsigned compare.
  - Zeroed by clearbtn, by the sweep, and by reset.
  - best_rating outputs the active user's best.
- When not defined, no best registers are built and best_rating is tied to 0.

Test Plan:
- Reset, state=2, set rating_in={4'h3,4'h7}, press updatebtn → cur_ratings=8'h37, cur_count=1, user=0.
- Press userbtn 4 times (NUM_USERS=4) → user goes 1,2,3,0. Hold userbtn 10 cycles → advances once only.
- At user=1, press updatebtn and clearbtn on the same edge → user1 ratings=0, count=0; user0 data unchanged.
- Press updatebtn 17 times with CNT_W=4 → cur_count saturates at 15.
- Load all 4 users with nonzero data, then press clearall → busy high exactly 4 cycles, then all_ratings=0. A userbtn press during busy is ignored (user unchanged). Repeat with reset pulsed at sweep cycle 2 → busy=0 immediately and all storage is 0.
- state=0, press updatebtn and userbtn → no change. With ACCOUNT_BEST_EN, update slot0 with 9 then 5 → best_rating=9; then clearbtn → 0.
